// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage for the RV32I core: owns the PC, issues one word read
// at a time over req/ack, and buffers the returned word for decode.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [6:0]  opcode
);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] req_addr, req_addr_next;
  logic [31:0] instr_next, instr_pc_next;
  logic        instr_valid_next;
  logic [31:0] target;
  logic        consume;

  assign target    = redirect_pc & 32'hFFFF_FFFC;
  assign consume   = instr_valid && !stall;
  assign imem_req  = (state == WAIT) || (state == DRAIN);
  assign imem_addr = req_addr;
  assign opcode    = instr[6:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      instr       <= 32'h0000_0013;
      instr_pc    <= 32'h0000_0000;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      req_addr    <= req_addr_next;
      instr       <= instr_next;
      instr_pc    <= instr_pc_next;
      instr_valid <= instr_valid_next;
    end
  end

  // A request is only issued when the slot is free or being consumed, so a
  // fill can never collide with a live instruction and no skid buffer exists.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    req_addr_next    = req_addr;
    instr_next       = instr;
    instr_pc_next    = instr_pc;
    instr_valid_next = instr_valid && !consume;

    case (state)
      IDLE: begin
        if (redirect_valid) begin
          pc_next          = target;
          instr_valid_next = 1'b0;
        end else if (!instr_valid || !stall) begin
          req_addr_next = pc;
          state_next    = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          state_next = IDLE;
          if (redirect_valid) begin
            pc_next          = target;
            instr_valid_next = 1'b0;
          end else begin
            instr_next       = imem_rdata;
            instr_pc_next    = req_addr;
            instr_valid_next = 1'b1;
            pc_next          = pc + 32'd4;
          end
        end else if (redirect_valid) begin
          pc_next          = target;
          instr_valid_next = 1'b0;
          state_next       = DRAIN;
        end
      end
      DRAIN: begin
        // The stale access must complete on the bus; its data is thrown away.
        if (redirect_valid) begin
          pc_next = target;
        end
        if (imem_ack) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic checked against a transaction model.
module tb_riscv_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [6:0]  opcode;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit chk_en = 1'b0;

  // Transaction-level model: next PC, one outstanding access (with a flag
  // saying its response is unwanted), and the decode slot.
  logic [31:0] m_pc    = RESET_PC;
  logic        m_busy  = 1'b0;
  logic [31:0] m_addr  = RESET_PC;
  logic        m_drop  = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = 32'h13;
  logic [31:0] m_ipc   = 32'h0;

  riscv_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .stall(stall),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .opcode(opcode)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cycle, act, exp);
    end
  endtask

  task automatic modelStep();
    logic [31:0] tgt;
    logic        consumed;
    tgt      = redirect_pc & 32'hFFFF_FFFC;
    consumed = m_valid && !stall;
    if (rst) begin
      m_pc = RESET_PC; m_busy = 1'b0; m_addr = RESET_PC; m_drop = 1'b0;
      m_valid = 1'b0; m_instr = 32'h13; m_ipc = 32'h0;
    end else if (m_busy) begin
      if (consumed) m_valid = 1'b0;
      if (imem_ack) begin
        m_busy = 1'b0;
        if (redirect_valid) begin
          m_pc = tgt; m_valid = 1'b0;
        end else if (!m_drop) begin
          m_instr = imem_rdata; m_ipc = m_addr; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end
      end else if (redirect_valid) begin
        m_pc = tgt; m_valid = 1'b0; m_drop = 1'b1;
      end
    end else begin
      if (redirect_valid) begin
        m_pc = tgt; m_valid = 1'b0;
      end else if (!m_valid || !stall) begin
        m_busy = 1'b1; m_addr = m_pc; m_drop = 1'b0;
        if (consumed) m_valid = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ack, input logic rv,
                               input logic [31:0] rpc, input logic st);
    rst            = r;
    imem_ack       = ack;
    imem_rdata     = memWord(imem_addr);
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall          = st;
    @(posedge clk);
    modelStep();
    cycle++;
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("imem_req",    32'(imem_req),    32'(m_busy));
      checkOutput("imem_addr",   imem_addr,        m_addr);
      checkOutput("instr_valid", 32'(instr_valid), 32'(m_valid));
      checkOutput("instr",       instr,            m_instr);
      checkOutput("instr_pc",    instr_pc,         m_ipc);
      checkOutput("opcode",      32'(opcode),      32'(m_instr[6:0]));
    end
  end

  initial begin
    logic        a, r, rv, st;
    logic [31:0] rpc;
    int          wait_cnt;

    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    $display("[TB] reset state");
    checkOutput("rst_req",    32'(imem_req),    0);
    checkOutput("rst_valid",  32'(instr_valid), 0);
    checkOutput("rst_instr",  instr,            32'h13);
    checkOutput("rst_opcode", 32'(opcode),      32'h13);
    checkOutput("rst_ipc",    instr_pc,         0);
    checkOutput("rst_addr",   imem_addr,        RESET_PC);

    $display("[TB] zero-wait fetches");
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("first_req",  32'(imem_req), 1);
    checkOutput("first_addr", imem_addr,     0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("fill0_valid", 32'(instr_valid), 1);
    checkOutput("fill0_ipc",   instr_pc,         0);
    checkOutput("fill0_op",    32'(opcode),      32'h13);
    checkOutput("fill0_req",   32'(imem_req),    0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("fetch4_addr",  imem_addr,        4);
    checkOutput("fetch4_valid", 32'(instr_valid), 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("fill4_valid", 32'(instr_valid), 1);
    checkOutput("fill4_ipc",   instr_pc,         4);
    checkOutput("fill4_instr", instr,            32'h00A0_0113);

    $display("[TB] stall hold");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("stall_req",   32'(imem_req),    0);
      checkOutput("stall_valid", 32'(instr_valid), 1);
      checkOutput("stall_ipc",   instr_pc,         4);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("unstall_req",  32'(imem_req), 1);
    checkOutput("unstall_addr", imem_addr,     8);

    $display("[TB] redirect during wait, drain");
    applyStimulus(0, 0, 1, 32'h0000_0103, 0);
    checkOutput("drain_req",   32'(imem_req),    1);
    checkOutput("drain_addr",  imem_addr,        8);
    checkOutput("drain_valid", 32'(instr_valid), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("drain2_addr", imem_addr, 8);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("drop_valid", 32'(instr_valid), 0);
    checkOutput("drop_req",   32'(imem_req),    0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("tgt_addr", imem_addr, 32'h100);

    $display("[TB] redirect with ack and with stall");
    applyStimulus(0, 1, 1, 32'h0000_0200, 0);
    checkOutput("rdack_valid", 32'(instr_valid), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rdack_addr", imem_addr, 32'h200);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("fill200_ipc", instr_pc, 32'h200);
    applyStimulus(0, 0, 1, 32'h0000_0300, 1);
    checkOutput("rdstall_valid", 32'(instr_valid), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rdstall_addr", imem_addr, 32'h300);
    applyStimulus(0, 1, 0, 0, 0);

    $display("[TB] pc wrap");
    applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wrap_next", imem_addr, 32'h0);

    $display("[TB] reset mid-request, late ack, 3 wait cycles");
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rstw_req", 32'(imem_req), 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("late_valid", 32'(instr_valid), 0);
    checkOutput("late_req",   32'(imem_req),    1);
    checkOutput("late_addr",  imem_addr,        RESET_PC);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("wait3_req",  32'(imem_req), 1);
      checkOutput("wait3_addr", imem_addr,     0);
    end
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("wait3_valid", 32'(instr_valid), 1);
    checkOutput("wait3_ipc",   instr_pc,         0);

    $display("[TB] random traffic");
    wait_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      a = 1'b0;
      if (imem_req) begin
        if (wait_cnt == 0) begin
          a = 1'b1;
          wait_cnt = int'($urandom_range(0, 3));
        end else begin
          wait_cnt--;
        end
      end else begin
        a = ($urandom_range(0, 7) == 0);
      end
      r   = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      st  = ($urandom_range(0, 2) == 0);
      applyStimulus(r, a, rv, rpc, st);
    end

    @(posedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
